// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the delay stage: presenter states and handshake pair
package pipe_pkg;

  // Presenter FSM: idle with nothing stored, counting down, or offering the head item.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } pres_state_e;

  // One valid/ready handshake pair.
  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  // A transfer happens on the edge where both sides agree.
  function automatic logic hs_fire(input hs_t hs);
    return hs.valid && hs.ready;
  endfunction

endpackage

// File: rtl/delay_stage_if.sv
// rtl/delay_stage_if.sv - upstream/downstream handshake bundle of the delay stage
interface delay_stage_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [$clog2(DEPTH):0]   occupancy;

  // Environment side: offers items and accepts results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/stage_fifo.sv
// rtl/stage_fifo.sv - small power-of-two FIFO holding the items waiting in the delay stage
module stage_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Guard against callers pushing when full or popping when empty.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign full_o  = (count_q == OCC_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
  end

  // Storage array is deliberately left unreset; only the bookkeeping matters.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - FIFO stage that adds a constant and presents each head item after a fixed wait
module delay_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int DEPTH  = 2,
  parameter int DELAY  = 4,
  parameter int ADDEND = 1
) (
  input  logic          clk,
  input  logic          reset,
  delay_stage_if.slave  bus
);

  localparam int CNT_W = $clog2(DELAY + 1);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);

  hs_t              in_hs;
  hs_t              out_hs;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] fifo_count;
  logic [OCC_W-1:0] occ_next;
  logic [WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0] sum;

  pres_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // in_ready comes from the registered count only, so it never sees out_ready.
  assign in_hs  = '{valid: bus.in_valid, ready: !fifo_full};
  assign out_hs = '{valid: (state_q == PRESENT), ready: bus.out_ready};
  assign push   = hs_fire(in_hs);
  assign pop    = hs_fire(out_hs);

  // Sum is truncated to WIDTH bits, so overflow wraps without any flag.
  assign sum = bus.in_data + WIDTH'(ADDEND);

  // Occupancy after this edge, counting an item that arrives together with the pop.
  assign occ_next = fifo_count + OCC_W'(push) - OCC_W'(pop);

  stage_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sum),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Presenter next state: wait DELAY cycles for each head item, then hold it until taken.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = PRESENT;
          out_data_d = fifo_head;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PRESENT: begin
        if (pop) begin
          if (occ_next != '0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Presenter registers; the captured out_data stays stable for the whole PRESENT phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = in_hs.ready;
  assign bus.out_valid = out_hs.valid;
  assign bus.out_data  = out_data_q;
  assign bus.occupancy = fifo_count;

endmodule

// File: tb/tb_delay_stage.sv
// tb/tb_delay_stage.sv - scoreboard bench for delay_stage (DELAY=4 main build, DELAY=1 side build)
module tb_delay_stage;
  import pipe_pkg::*;

  localparam int WIDTH  = 5;
  localparam int DEPTH  = 2;
  localparam int DELAY  = 4;
  localparam int ADDEND = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  delay_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc  ();
  delay_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc1 ();

  delay_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY(DELAY), .ADDEND(ADDEND)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  delay_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY(1), .ADDEND(ADDEND)) u_d1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc1)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];

  // Reference: each stored value is the input plus ADDEND, modulo 2^WIDTH.
  function automatic int model(input int d);
    return (d + ADDEND) % (1 << WIDTH);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offset n such that out_valid is first seen after edge (last edge + n); -1 on timeout.
  task automatic wait_out(output int n, input int limit);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ifc.out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  // Monitor: records accepted items and checks every delivered one against the queue.
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (ifc.out_valid && prev_hold) begin
        check("hold_stable", int'(ifc.out_data), int'(prev_data));
      end
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          check("phantom_item", 1, 0);
        end else begin
          check("sb_data", int'(ifc.out_data), exp_q.pop_front());
        end
      end
      if (ifc.in_valid && ifc.in_ready) begin
        exp_q.push_back(model(int'(ifc.in_data)));
      end
      prev_hold = ifc.out_valid && !ifc.out_ready;
      prev_data = ifc.out_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int off;
    int pushes;
    int acc;
    int seen;
    int q1[$];
    int last_pop;
    int pops;

    ifc.in_valid   = 1'b0;
    ifc.in_data    = '0;
    ifc.out_ready  = 1'b0;
    ifc1.in_valid  = 1'b0;
    ifc1.in_data   = '0;
    ifc1.out_ready = 1'b0;

    // Reset low for two edges, checked during and after.
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("rst_out_valid", int'(ifc.out_valid), 0);
    check("rst_in_ready", int'(ifc.in_ready), 1);
    check("rst_occupancy", int'(ifc.occupancy), 0);
    check("rst_out_data", int'(ifc.out_data), 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(ifc.in_ready), 1);
    check("post_rst_out_valid", int'(ifc.out_valid), 0);
    tick();

    // Single item: 3 -> 4, visible after edge k+1+DELAY.
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 5'd3;
    tick();
    ifc.in_valid  = 1'b0;
    wait_out(off, 40);
    check("single_latency", off, 1 + DELAY);
    check("single_data", int'(ifc.out_data), 4);
    tick();
    @(negedge clk);
    check("single_occ_after", int'(ifc.occupancy), 0);
    check("single_idle", int'(u_dut.state_q), int'(IDLE));
    tick();

    // Wrap: 31 + 1 -> 0.
    ifc.in_valid = 1'b1;
    ifc.in_data  = 5'd31;
    tick();
    ifc.in_valid = 1'b0;
    wait_out(off, 40);
    check("wrap_latency", off, 1 + DELAY);
    check("wrap_data", int'(ifc.out_data), 0);
    tick();
    tick();

    // Backpressure: fill the FIFO while downstream stalls, third item stays offered.
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    pushes = 0;
    for (int c = 0; c < 20 && pushes < 2; c++) begin
      @(negedge clk);
      acc = int'(ifc.in_ready);
      tick();
      if (acc != 0) begin
        pushes++;
        ifc.in_data = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      end
    end
    @(negedge clk);
    check("bp_in_ready_full", int'(ifc.in_ready), 0);
    check("bp_occupancy_full", int'(ifc.occupancy), 2);
    wait_out(off, 40);
    check("bp_present_reached", int'(off >= 0), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
    end
    @(negedge clk);
    check("bp_still_full", int'(ifc.in_ready), 0);
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_no_comb_path", int'(ifc.in_ready), 0);
    check("bp_valid_before_pop", int'(ifc.out_valid), 1);
    tick();                                   // pop edge j
    @(negedge clk);
    check("bp_in_ready_after_pop", int'(ifc.in_ready), 1);
    check("bp_occ_after_pop", int'(ifc.occupancy), 1);
    tick();                                   // push edge j+1
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("bp_occ_refill", int'(ifc.occupancy), 2);
    wait_out(off, 40);
    // off is measured from edge j+2, so the gap from the pop at j is off+2.
    check("bp_gap_second", off + 2, DELAY);
    tick();
    wait_out(off, 40);
    check("bp_gap_third", off, DELAY);
    tick();
    @(negedge clk);
    check("bp_drained", int'(ifc.occupancy), 0);
    tick();

    // Mid-operation reset while WAIT with two stored items.
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 5'd10;
    tick();
    ifc.in_data   = 5'd20;
    tick();
    ifc.in_valid  = 1'b0;
    @(negedge clk);
    check("mr_occ_before", int'(ifc.occupancy), 2);
    check("mr_state_wait", int'(u_dut.state_q), int'(WAIT));
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mr_out_valid", int'(ifc.out_valid), 0);
    check("mr_occupancy", int'(ifc.occupancy), 0);
    check("mr_in_ready", int'(ifc.in_ready), 1);
    ifc.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.out_valid) seen = 1;
    end
    check("mr_no_old_item", seen, 0);
    tick();

    // Randomized traffic checked by the scoreboard.
    for (int c = 0; c < 500; c++) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.in_data   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ifc.occupancy == 0 && !ifc.out_valid) break;
    end
    check("rand_drained_occ", int'(ifc.occupancy), 0);
    check("rand_sb_empty", exp_q.size(), 0);
    tick();

    // DELAY=1 build: latency k+2 and one item every two cycles when streaming.
    ifc1.out_ready = 1'b1;
    ifc1.in_valid  = 1'b1;
    ifc1.in_data   = 5'd9;
    tick();
    ifc1.in_valid  = 1'b0;
    off = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc1.out_valid) begin
        off = i;
        break;
      end
    end
    check("d1_latency", off, 2);
    check("d1_data", int'(ifc1.out_data), 10);
    tick();
    tick();

    ifc1.in_valid = 1'b1;
    ifc1.in_data  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    last_pop = -1;
    pops = 0;
    for (int c = 0; c < 60 && pops < 10; c++) begin
      @(negedge clk);
      if (ifc1.out_valid && ifc1.out_ready) begin
        if (q1.size() == 0) check("d1_phantom", 1, 0);
        else check("d1_stream_data", int'(ifc1.out_data), q1.pop_front());
        if (last_pop >= 0) check("d1_stream_gap", c - last_pop, 2);
        last_pop = c;
        pops++;
      end
      acc = int'(ifc1.in_valid && ifc1.in_ready);
      if (acc != 0) q1.push_back(model(int'(ifc1.in_data)));
      tick();
      if (acc != 0) ifc1.in_data = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    end
    ifc1.in_valid = 1'b0;
    check("d1_stream_count", pops, 10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/delay_stage.md
DELAY_STAGE -- requirements
Module: delay_stage

Interface
REQ-001 Parameter WIDTH, default 5, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 2, FIFO entries (power of two, >=2).
REQ-003 Parameter DELAY, default 4, cycles the head item waits before it is presented (>=1).
REQ-004 Parameter ADDEND, default 1, constant added to every accepted item.
REQ-005 clk  input  1  sole clock, all state updates on posedge.
REQ-006 reset  input  1  reset, synchronous, active-low: when low at a posedge, all state returns to its reset values.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  stage can accept an item this cycle.
REQ-009 in_data  input  WIDTH  upstream item.
REQ-010 out_valid  output  1  out_data is presented to downstream.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  WIDTH  presented item.
REQ-013 occupancy  output  $clog2(DEPTH)+1  number of items currently stored.

Function
REQ-014 Push occurs when in_valid && in_ready at a posedge; pop occurs when out_valid && out_ready at a posedge.
REQ-015 in_ready SHALL equal (occupancy < DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-016 Stored value = (in_data + ADDEND) mod 2^WIDTH; overflow wraps silently, with no flag.
REQ-017 Items leave in FIFO order; none are dropped or duplicated.
REQ-018 The presenter FSM has states IDLE, WAIT and PRESENT.
REQ-019 IDLE: if occupancy > 0, the FSM goes to WAIT and loads the counter with DELAY-1; otherwise it stays in IDLE.
REQ-020 WAIT: if the counter is 0, the FSM goes to PRESENT; otherwise it decrements the counter.
REQ-021 PRESENT: out_valid=1 and out_data=head; on pop, it goes to WAIT with counter DELAY-1 if occupancy after the pop > 0, else to IDLE; without a pop it holds and out_data stays stable.
REQ-022 out_valid SHALL be 1 only in PRESENT.
REQ-023 Latency: for an item pushed into an empty, IDLE stage at edge k, out_valid rises after edge k+1+DELAY.
REQ-024 Simultaneous push and pop: occupancy is unchanged and both transfers complete.
REQ-025 Push when full is impossible, because in_ready=0; a pop when full frees space, but in_ready rises only in the next cycle.
REQ-026 The counter width SHALL be $clog2(DELAY+1), and the counter SHALL never underflow.
REQ-027 Head/tail pointers wrap modulo DEPTH.

Reset
REQ-028 While reset is low at a posedge: FSM=IDLE, counter=0, pointers=0, occupancy=0.
REQ-029 Output values during and after reset: out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-030 Reset asserted mid-operation (WAIT or PRESENT, any occupancy) SHALL discard all stored items within that same edge.
REQ-031 FIFO storage contents need no reset; only the out_data register is cleared.

Structure
REQ-032 Shared package pipe_pkg SHALL hold the presenter state enum (IDLE, WAIT, PRESENT) and a typedef for the handshake pair {valid, ready}.
REQ-033 The FIFO SHALL be one sub-module, stage_fifo (parameters WIDTH, DEPTH), exposing push, pop, full, empty, count and head.
REQ-034 The FSM, counter and adder SHALL reside in delay_stage itself.

Verification
REQ-035 Reset then single item: reset low 2 cycles, push in_data=3 at edge k, out_ready=1 -> out_valid rises after edge k+5 with out_data=4, then occupancy=0 and state IDLE.
REQ-036 Wrap: push in_data=31 (WIDTH=5) -> out_data=0.
REQ-037 Backpressure: out_ready=0, push 3 items -> in_ready=0 after 2 pushes (DEPTH=2), occupancy=2; out_data holds stable in PRESENT; releasing out_ready yields values in order, each separated by DELAY+1 cycles.
REQ-038 Simultaneous: at full in PRESENT with out_ready=1 and in_valid=1 -> pop at edge j, in_ready=1 in cycle j+1, push accepted at j+1, occupancy back to 2.
REQ-039 Mid-operation reset: occupancy=2 in WAIT, reset low for one edge -> out_valid=0, occupancy=0, in_ready=1 next cycle; no old item is ever presented.
REQ-040 DELAY=1 build: an item pushed at edge k gives out_valid after edge k+2, and streaming with out_ready=1 achieves one item per 2 cycles.
